// File: rtl/tiny_cpu_4b.sv
// tiny_cpu_4b -- 4-bit accumulator CPU in the TinyTapeout user-project wrapper.
//
// Instruction bytes are streamed into a 16x8 program RAM while mode=0. While
// mode=1, one instruction executes per clock from that RAM against a 4-bit
// accumulator, carry/zero flags and a 16x4 data RAM. HLT freezes execution
// until mode returns to 0 or reset.
//
// Ports:
//   clk      in   1  system clock, rising edge
//   rst_n    in   1  asynchronous active-low reset (also clears both RAMs)
//   ena      in   1  design enable; 0 = all state holds
//   ui_in    in   8  instruction byte: [7:4] opcode, [3:0] imm/address
//   uio_in   in   8  [0] mode: 0=program, 1=run; [7:1] ignored
//   uo_out   out  8  {mode, HALT, Z, C, ACC[3:0]}, all registered
//   uio_out  out  8  constant 0
//   uio_oe   out  8  constant 0 (all uio pins are inputs)
module tiny_cpu_4b (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   typedef enum logic [3:0] {
      OP_NOP  = 4'h0,
      OP_LDI  = 4'h1,
      OP_ADDI = 4'h2,
      OP_SUBI = 4'h3,
      OP_ANDI = 4'h4,
      OP_ORI  = 4'h5,
      OP_XORI = 4'h6,
      OP_NOT  = 4'h7,
      OP_SHL  = 4'h8,
      OP_SHR  = 4'h9,
      OP_STA  = 4'hA,
      OP_LDA  = 4'hB,
      OP_JMP  = 4'hC,
      OP_JZ   = 4'hD,
      OP_JC   = 4'hE,
      OP_HLT  = 4'hF
   } opcode_e;

   logic [7:0] prog_q [16];
   logic [7:0] prog_d [16];
   logic [3:0] dmem_q [16];
   logic [3:0] dmem_d [16];

   logic [3:0] acc_q, acc_d;
   logic       c_q, c_d;
   logic       z_q, z_d;
   logic       halt_q, halt_d;
   logic [3:0] pc_q, pc_d;
   logic [3:0] wp_q, wp_d;
   logic       mode_q, mode_d;

   logic [7:0] instr;
   opcode_e    op;
   logic [3:0] imm;
   logic [4:0] sum;
   logic [3:0] res;
   logic       wr_acc;

   logic       unused_uio;

   assign instr = prog_q[pc_q];
   assign op    = opcode_e'(instr[7:4]);
   assign imm   = instr[3:0];
   assign sum   = {1'b0, acc_q} + {1'b0, imm};

   always_comb begin
      prog_d = prog_q;
      dmem_d = dmem_q;
      acc_d  = acc_q;
      c_d    = c_q;
      z_d    = z_q;
      halt_d = halt_q;
      pc_d   = pc_q;
      wp_d   = wp_q;
      mode_d = mode_q;
      res    = acc_q;
      wr_acc = 1'b0;

      if (ena) begin
         mode_d = uio_in[0];
         if (!uio_in[0]) begin
            prog_d[wp_q] = ui_in;
            wp_d   = wp_q + 4'd1;
            pc_d   = '0;
            acc_d  = '0;
            c_d    = 1'b0;
            z_d    = 1'b0;
            halt_d = 1'b0;
         end else begin
            wp_d = '0;
            if (!halt_q) begin
               pc_d = pc_q + 4'd1;
               unique case (op)
                  OP_NOP:  ;
                  OP_LDI:  begin res = imm;             wr_acc = 1'b1; end
                  OP_ADDI: begin res = sum[3:0]; c_d = sum[4]; wr_acc = 1'b1; end
                  OP_SUBI: begin res = acc_q - imm; c_d = (acc_q < imm); wr_acc = 1'b1; end
                  OP_ANDI: begin res = acc_q & imm;     wr_acc = 1'b1; end
                  OP_ORI:  begin res = acc_q | imm;     wr_acc = 1'b1; end
                  OP_XORI: begin res = acc_q ^ imm;     wr_acc = 1'b1; end
                  OP_NOT:  begin res = ~acc_q;          wr_acc = 1'b1; end
                  OP_SHL:  begin res = {acc_q[2:0], 1'b0}; c_d = acc_q[3]; wr_acc = 1'b1; end
                  OP_SHR:  begin res = {1'b0, acc_q[3:1]}; c_d = acc_q[0]; wr_acc = 1'b1; end
                  OP_STA:  dmem_d[imm] = acc_q;
                  OP_LDA:  begin res = dmem_q[imm];     wr_acc = 1'b1; end
                  OP_JMP:  pc_d = imm;
                  OP_JZ:   if (z_q) pc_d = imm;
                  OP_JC:   if (c_q) pc_d = imm;
                  OP_HLT:  begin halt_d = 1'b1; pc_d = pc_q; end
               endcase
               // Every ACC-writing opcode also refreshes Z from its result.
               if (wr_acc) begin
                  acc_d = res;
                  z_d   = (res == 4'd0);
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 16; i++) begin
            prog_q[i] <= '0;
            dmem_q[i] <= '0;
         end
         acc_q  <= '0;
         c_q    <= 1'b0;
         z_q    <= 1'b0;
         halt_q <= 1'b0;
         pc_q   <= '0;
         wp_q   <= '0;
         mode_q <= 1'b0;
      end else begin
         prog_q <= prog_d;
         dmem_q <= dmem_d;
         acc_q  <= acc_d;
         c_q    <= c_d;
         z_q    <= z_d;
         halt_q <= halt_d;
         pc_q   <= pc_d;
         wp_q   <= wp_d;
         mode_q <= mode_d;
      end
   end

   assign uo_out     = {mode_q, halt_q, z_q, c_q, acc_q};
   assign uio_out    = '0;
   assign uio_oe     = '0;
   assign unused_uio = &{1'b0, uio_in[7:1]};

endmodule

// File: tb/tb_tiny_cpu_4b.sv
// tb_tiny_cpu_4b -- directed vector table plus randomized programs for
// tiny_cpu_4b, checked against constant expectations and an instruction-level
// reference model of the CPU.
module tb_tiny_cpu_4b;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int checks   = 0;
   int failures = 0;

   tiny_cpu_4b dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int m_prog [16];
   int m_dmem [16];
   int m_acc, m_c, m_z, m_halt, m_pc, m_wp, m_mode;

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_prog[i] = 0;
         m_dmem[i] = 0;
      end
      m_acc = 0; m_c = 0; m_z = 0; m_halt = 0; m_pc = 0; m_wp = 0; m_mode = 0;
   endtask

   task automatic model_step(input bit e, input bit m, input int ui);
      int op, imm, nxt, r;
      if (!e) return;
      m_mode = m;
      if (!m) begin
         m_prog[m_wp] = ui;
         m_wp   = (m_wp + 1) % 16;
         m_pc   = 0;
         m_acc  = 0; m_c = 0; m_z = 0; m_halt = 0;
         return;
      end
      m_wp = 0;
      if (m_halt != 0) return;
      op  = m_prog[m_pc] / 16;
      imm = m_prog[m_pc] % 16;
      nxt = (m_pc + 1) % 16;
      case (op)
         1:  m_acc = imm;
         2:  begin r = m_acc + imm; m_c = (r > 15); m_acc = r % 16; end
         3:  begin m_c = (m_acc < imm); m_acc = (m_acc - imm + 16) % 16; end
         4:  m_acc = m_acc & imm;
         5:  m_acc = m_acc | imm;
         6:  m_acc = m_acc ^ imm;
         7:  m_acc = 15 - m_acc;
         8:  begin m_c = (m_acc >= 8); m_acc = (m_acc * 2) % 16; end
         9:  begin m_c = m_acc % 2; m_acc = m_acc / 2; end
         10: m_dmem[imm] = m_acc;
         11: m_acc = m_dmem[imm];
         12: nxt = imm;
         13: if (m_z != 0) nxt = imm;
         14: if (m_c != 0) nxt = imm;
         15: begin m_halt = 1; nxt = m_pc; end
         default: ;
      endcase
      if ((op >= 1 && op <= 9) || op == 11) m_z = (m_acc == 0);
      m_pc = nxt;
   endtask

   function automatic logic [7:0] model_uo();
      return 8'(m_mode * 128 + m_halt * 64 + m_z * 32 + m_c * 16 + m_acc);
   endfunction

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   // Drive one clock's inputs, let the edge happen, then compare 1 ns later.
   task automatic cycle(input bit e, input bit m, input logic [7:0] ui,
                        input bit has_exp, input logic [7:0] exp, input string name);
      logic [6:0] junk;
      junk   = 7'($urandom);
      ena    = e;
      uio_in = {junk, m};
      ui_in  = ui;
      @(posedge clk);
      #1;
      model_step(e, m, int'(ui));
      check({name, "_model"}, uo_out, model_uo());
      if (has_exp) check(name, uo_out, exp);
   endtask

   // Reset asserted between edges: outputs must clear without waiting for a clock.
   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("reset_uo_out", uo_out, 8'h00);
      check("reset_uio_oe", uio_oe, 8'h00);
      check("reset_uio_out", uio_out, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit         rst;
      bit         e;
      bit         m;
      logic [7:0] ui;
      int         rep;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs [$];

   task automatic add(input bit rst, input bit e, input bit m,
                      input logic [7:0] ui, input int rep, input logic [7:0] exp);
      vec_t v;
      v.rst = rst; v.e = e; v.m = m; v.ui = ui; v.rep = rep; v.exp = exp;
      vecs.push_back(v);
   endtask

   task automatic prog(input bit rst, input logic [7:0] ui);
      add(rst, 1'b1, 1'b0, ui, 1, 8'h00);
   endtask

   task automatic run(input int rep, input logic [7:0] exp);
      add(1'b0, 1'b1, 1'b1, 8'hFF, rep, exp);
   endtask

   initial begin
      rst_n  = 1'b0;
      ena    = 1'b0;
      ui_in  = '0;
      uio_in = '0;
      model_reset();

      // Idle program mode after reset keeps outputs at zero.
      prog(1'b1, 8'h00); prog(1'b0, 8'h00);

      // Arithmetic and wrap-around to a second pass.
      prog(1'b1, 8'h21); prog(1'b0, 8'h31); prog(1'b0, 8'h42); prog(1'b0, 8'h52);
      run(1, 8'h81); run(1, 8'hA0); run(1, 8'hA0); run(1, 8'h82);
      run(12, 8'h82);
      run(1, 8'h83); run(1, 8'h82); run(1, 8'h82); run(1, 8'h82);

      // Carry out of ADDI, borrow from SUBI.
      prog(1'b1, 8'h1F); prog(1'b0, 8'h21);
      run(1, 8'h8F); run(1, 8'hB0);
      prog(1'b0, 8'h10); prog(1'b0, 8'h31);
      run(1, 8'hA0); run(1, 8'h9F);

      // Data RAM round trip, then HALT freezes.
      prog(1'b1, 8'h15); prog(1'b0, 8'hA3); prog(1'b0, 8'h10);
      prog(1'b0, 8'hB3); prog(1'b0, 8'hF0);
      run(1, 8'h85); run(1, 8'h85); run(1, 8'hA0); run(1, 8'h85);
      run(1, 8'hC5); run(3, 8'hC5);

      // JZ taken, JMP self-loop.
      prog(1'b1, 8'h10); prog(1'b0, 8'hD3); prog(1'b0, 8'h1F);
      prog(1'b0, 8'h17); prog(1'b0, 8'hC4);
      run(1, 8'hA0); run(1, 8'hA0); run(1, 8'h87); run(5, 8'h87);
      // ena=0 freezes a running CPU; mode drop clears; ena=0 also freezes mode reg.
      add(1'b0, 1'b0, 1'b1, 8'hFF, 3, 8'h87);
      prog(1'b0, 8'h00);
      add(1'b0, 1'b0, 1'b1, 8'hFF, 2, 8'h00);
      add(1'b0, 1'b0, 1'b0, 8'h55, 1, 8'h00);
      // prog[0] now NOP; JZ at 1 not taken because Z was cleared.
      run(1, 8'h80); run(1, 8'h80); run(1, 8'h8F); run(1, 8'h87);

      // Shifts, XOR, NOT, JC taken into a HLT.
      prog(1'b1, 8'h1B); prog(1'b0, 8'h80); prog(1'b0, 8'h90); prog(1'b0, 8'h6F);
      prog(1'b0, 8'h70); prog(1'b0, 8'h1F); prog(1'b0, 8'h80); prog(1'b0, 8'hE9);
      prog(1'b0, 8'h10); prog(1'b0, 8'hF0);
      run(1, 8'h8B); run(1, 8'h96); run(1, 8'h83); run(1, 8'h8C); run(1, 8'h83);
      run(1, 8'h8F); run(1, 8'h9E); run(1, 8'h9E); run(2, 8'hDE);

      // Reset mid-run clears data RAM and program RAM.
      prog(1'b1, 8'h1A); prog(1'b0, 8'hA0);
      run(1, 8'h8A); run(1, 8'h8A);
      prog(1'b1, 8'hB0);
      run(1, 8'hA0);
      add(1'b1, 1'b1, 1'b1, 8'hFF, 3, 8'h80);

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].rst) do_reset();
         for (int r = 0; r < vecs[i].rep; r++)
            cycle(vecs[i].e, vecs[i].m, vecs[i].ui, 1'b1, vecs[i].exp,
                  $sformatf("vec%0d_%0d", i, r));
      end

      // Randomized programs against the reference model.
      for (int blk = 0; blk < 10; blk++) begin
         if (blk % 3 == 0) do_reset();
         for (int k = 0; k < 16; k++)
            cycle(($urandom_range(9) != 0), 1'b0, 8'($urandom), 1'b0, 8'h00,
                  $sformatf("rnd_prog%0d_%0d", blk, k));
         for (int k = 0; k < 40; k++)
            cycle(($urandom_range(9) != 0), ($urandom_range(19) != 0), 8'($urandom),
                  1'b0, 8'h00, $sformatf("rnd_run%0d_%0d", blk, k));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
